flash_audio_streamer: RTL

FLASH_AUDIO_STREAMER -- requirements
Module: flash_audio_streamer

---
 rtl/flash_audio_streamer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/flash_audio_streamer.sv
// flash_audio_streamer: prefetches PCM words from Avalon flash and streams attenuated samples to a codec
module flash_audio_streamer #(
    parameter int ADDR_W      = 23,
    parameter int SAMPLE_W    = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int ATTEN_SHIFT = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  loop_en,
    input  logic                  stereo,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W-1:0]     end_addr,
    output logic                  flash_mem_read,
    output logic [ADDR_W-1:0]     flash_mem_address,
    input  logic                  flash_mem_waitrequest,
    input  logic [2*SAMPLE_W-1:0] flash_mem_readdata,
    input  logic                  flash_mem_readdatavalid,
    input  logic                  write_ready,
    output logic                  write_s,
    output logic [SAMPLE_W-1:0]   writedata_left,
    output logic [SAMPLE_W-1:0]   writedata_right,
    output logic                  busy,
    output logic                  done,
    output logic [23:0]           sample_count
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} f_state_t;
    typedef enum logic [1:0] {S_IDLE, S_READY, S_WRITE, S_LOW} s_state_t;

    f_state_t f_state, f_next;
    s_state_t s_state, s_next;

    logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic [ADDR_W-1:0] s_addr, e_addr;
    logic last_fetched, stopping, half, word_st, cur_st;
    logic push, pop, load, fin, empty, full, at_end;
    logic [SAMPLE_W-1:0] lo_a, hi_a;

    function automatic logic [SAMPLE_W-1:0] atten(input logic [SAMPLE_W-1:0] x);
        return $signed(x) >>> ATTEN_SHIFT;
    endfunction

    assign empty = count == '0;
    assign full = count == (PW+1)'(FIFO_DEPTH);
    assign at_end = flash_mem_address == e_addr;
    assign push = f_state == F_WAIT && flash_mem_readdatavalid && !stopping && !stop && !full;
    assign cur_st = half ? word_st : stereo;
    assign lo_a = atten(mem[rd_ptr][SAMPLE_W-1:0]);
    assign hi_a = atten(mem[rd_ptr][2*SAMPLE_W-1:SAMPLE_W]);
    assign load = s_state == S_READY && !stop && !empty && !pause && write_ready;
    assign fin = s_state == S_READY && !stop && empty && last_fetched && f_state == F_IDLE;
    assign pop = s_state == S_LOW && !stop && (word_st || half);
    assign flash_mem_read = f_state == F_REQ;
    assign write_s = s_state == S_WRITE;

    // state registers for both FSMs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_state <= F_IDLE;
            s_state <= S_IDLE;
        end else begin
            f_state <= f_next;
            s_state <= s_next;
        end
    end

    // fetch: one outstanding read at a time, only when a FIFO slot is free
    always_comb begin
        f_next = f_state;
        case (f_state)
            F_IDLE: if (busy && !stop && !stopping && !last_fetched && !full) f_next = F_REQ;
            F_REQ: if (!flash_mem_waitrequest) f_next = F_WAIT;
            F_WAIT: if (flash_mem_readdatavalid) f_next = F_IDLE;
            default: f_next = F_IDLE;
        endcase
    end

    // sink: codec write handshake, stop drops straight to idle
    always_comb begin
        s_next = s_state;
        case (s_state)
            S_IDLE: if (start && !busy) s_next = S_READY;
            S_READY: s_next = (stop || fin) ? S_IDLE : load ? S_WRITE : S_READY;
            S_WRITE: s_next = stop ? S_IDLE : !write_ready ? S_LOW : S_WRITE;
            S_LOW: s_next = stop ? S_IDLE : S_READY;
            default: s_next = S_IDLE;
        endcase
    end

    // FIFO storage needs no reset; occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= flash_mem_readdata;
    end

    // playback control, address sequencing, FIFO pointers and sample registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_mem_address <= '0;
            s_addr <= '0;
            e_addr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            stopping <= 1'b0;
            last_fetched <= 1'b0;
            half <= 1'b0;
            word_st <= 1'b0;
            writedata_left <= '0;
            writedata_right <= '0;
            sample_count <= '0;
        end else begin
            done <= fin;
            if (start && !busy) begin
                s_addr <= start_addr;
                e_addr <= end_addr;
                flash_mem_address <= start_addr;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
                sample_count <= '0;
                busy <= 1'b1;
                stopping <= 1'b0;
                last_fetched <= 1'b0;
                half <= 1'b0;
            end else if (stop && busy) begin
                stopping <= 1'b1;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
                half <= 1'b0;
            end else begin
                if ((stopping && f_state == F_IDLE) || fin) begin
                    busy <= 1'b0;
                    stopping <= 1'b0;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    flash_mem_address <= (at_end && loop_en) ? s_addr : flash_mem_address + 1'b1;
                    if (at_end && !loop_en) last_fetched <= 1'b1;
                end
                if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (load) begin
                    word_st <= cur_st;
                    writedata_left <= (cur_st || !half) ? lo_a : hi_a;
                    writedata_right <= (cur_st || half) ? hi_a : lo_a;
                end
                if (s_state == S_LOW && !stop) begin
                    half <= !word_st && !half;
                    if (sample_count != '1) sample_count <= sample_count + 1'b1;
                end
            end
        end
    end
endmodule
